// File: rtl/piano_sequencer_if.sv
// piano_sequencer_if
//   Bundles the debounced player controls going into the sequencer and the
//   note/status signals coming out of it. The clock and reset stay outside
//   the bundle as plain ports.
//
//   master modport : the input stage side (drives tick, switches, octave,
//                    toggle_pb, clear; observes tone and status outputs)
//   slave modport  : the sequencer side
//
//   Signals:
//     tick          one-cycle sample/playback strobe
//     note_switches debounced note levels, bit0=C .. bit6=B
//     octave        current octave, 1..7
//     toggle_pb     debounced level, rising edge requests a mode toggle
//     clear         debounced level, rising edge erases the recording
//     note_out      note code to the tone generator, 0=rest, 1..7=C..B
//     octave_out    octave to the tone generator
//     pb_mode       high while playing back
//     full          high when the buffer holds DEPTH entries
//     count         number of valid entries, 0..DEPTH
interface piano_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              tick;
  logic [6:0]        note_switches;
  logic [2:0]        octave;
  logic              toggle_pb;
  logic              clear;
  logic [2:0]        note_out;
  logic [2:0]        octave_out;
  logic              pb_mode;
  logic              full;
  logic [ADDR_W:0]   count;

  modport master (
    output tick, note_switches, octave, toggle_pb, clear,
    input  note_out, octave_out, pb_mode, full, count
  );

  modport slave (
    input  tick, note_switches, octave, toggle_pb, clear,
    output note_out, octave_out, pb_mode, full, count
  );
endinterface

// File: rtl/piano_sequencer.sv
// piano_sequencer
//   Record/playback controller for the note buffer. On each tick it either
//   records {octave, note} into the buffer (REC_IDLE arms on the first
//   non-rest note, REC records every tick including rests) or replays one
//   stored entry per tick (PLAY). Outside PLAY the tone outputs follow the
//   live input with one cycle of latency.
//
//   Ports:
//     clk    system clock
//     rst_n  synchronous active-low reset, sampled on the rising edge of clk
//     bus    piano_sequencer_if.slave carrying the controls and outputs
//
//   Optional feature:
//     PIANO_SEQ_LOOP_EN  when defined, playback loops back to entry 0 at the
//                        end of the sequence instead of returning to REC_IDLE.
module piano_sequencer #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  piano_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    REC_IDLE = 2'd0,
    REC      = 2'd1,
    PLAY     = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C      = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ZERO_C     = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W-1:0] IDX_ZERO_C = {ADDR_W{1'b0}};

  // Lowest pressed switch wins; no switch pressed encodes a rest.
  function automatic logic [2:0] enc_note(input logic [6:0] sw);
    logic [2:0] code;
    casez (sw)
      7'b??????1: code = 3'd1;
      7'b?????10: code = 3'd2;
      7'b????100: code = 3'd3;
      7'b???1000: code = 3'd4;
      7'b??10000: code = 3'd5;
      7'b?100000: code = 3'd6;
      7'b1000000: code = 3'd7;
      default:    code = 3'd0;
    endcase
    return code;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [ADDR_W:0]   count_r, count_nxt_s, count_inc_s;
  logic              full_r, full_nxt_s;
  logic [ADDR_W-1:0] rd_idx_r, rd_idx_nxt_s;
  // Set once the last valid entry has been output; lets a full buffer
  // (count==DEPTH) end playback even though rd_idx cannot hold DEPTH.
  logic              rd_done_r, rd_done_nxt_s;
  logic [ADDR_W:0]   rd_base_s, rd_pos_s;
  logic [ADDR_W-1:0] pf_addr_s;
  logic [2:0]        note_out_r, note_nxt_s;
  logic [2:0]        octave_out_r, oct_nxt_s;
  logic              pb_mode_r;
  logic              toggle_prev_r, toggle_rise_r;
  logic              clear_prev_r, clear_rise_r;
  logic              wr_en_s, load_s;
  logic [2:0]        live_note_s;
  logic [5:0]        wr_data_s;
  logic [5:0]        rd_data_r;
  logic [5:0]        mem_r [DEPTH];

  assign live_note_s = enc_note(bus.note_switches);
  assign wr_data_s   = {bus.octave, live_note_s};

  // Next-state, index, write-enable and tone-output selection.
  always_comb begin
    state_nxt_s   = state_r;
    count_nxt_s   = count_r;
    full_nxt_s    = full_r;
    rd_idx_nxt_s  = rd_idx_r;
    rd_done_nxt_s = rd_done_r;
    wr_en_s       = 1'b0;
    load_s        = 1'b0;
    note_nxt_s    = note_out_r;
    oct_nxt_s     = octave_out_r;
    count_inc_s   = count_r + ONE_C;
    // After the end of the sequence the next read position restarts at 0.
    rd_base_s     = rd_done_r ? ZERO_C : {1'b0, rd_idx_r};
    rd_pos_s      = rd_base_s + ONE_C;

    // A tick in the same cycle as a clear or toggle rise is dropped.
    if (clear_rise_r) begin
      state_nxt_s   = REC_IDLE;
      count_nxt_s   = ZERO_C;
      full_nxt_s    = 1'b0;
      rd_idx_nxt_s  = IDX_ZERO_C;
      rd_done_nxt_s = 1'b0;
    end else if (toggle_rise_r) begin
      case (state_r)
        REC_IDLE, REC: begin
          if (count_r != ZERO_C) begin
            state_nxt_s   = PLAY;
            rd_idx_nxt_s  = IDX_ZERO_C;
            rd_done_nxt_s = 1'b0;
          end else begin
            state_nxt_s = REC_IDLE;
          end
        end
        PLAY:    state_nxt_s = REC_IDLE;
        default: state_nxt_s = REC_IDLE;
      endcase
    end else if (bus.tick) begin
      case (state_r)
        REC_IDLE: begin
          if ((live_note_s != 3'd0) && !full_r) begin
            wr_en_s = 1'b1;
          end else begin
            wr_en_s = 1'b0;
          end
        end
        REC: begin
          if (!full_r) begin
            wr_en_s = 1'b1;
          end else begin
            state_nxt_s = REC_IDLE;
          end
        end
        PLAY: begin
`ifdef PIANO_SEQ_LOOP_EN
          load_s        = 1'b1;
          rd_idx_nxt_s  = rd_pos_s[ADDR_W-1:0];
          rd_done_nxt_s = (rd_pos_s == count_r);
`else
          if (rd_done_r) begin
            state_nxt_s = REC_IDLE;
          end else begin
            load_s        = 1'b1;
            rd_idx_nxt_s  = rd_pos_s[ADDR_W-1:0];
            rd_done_nxt_s = (rd_pos_s == count_r);
          end
`endif
        end
        default: state_nxt_s = REC_IDLE;
      endcase

      if (wr_en_s) begin
        count_nxt_s = count_inc_s;
        if (count_inc_s == DEPTH_C) begin
          full_nxt_s  = 1'b1;
          state_nxt_s = REC_IDLE;
        end else begin
          state_nxt_s = REC;
        end
      end else begin
        count_nxt_s = count_r;
      end
    end else begin
      state_nxt_s = state_r;
    end

    // Outputs: live outside PLAY, 0/0 on PLAY entry, else loaded or held.
    if (state_nxt_s != PLAY) begin
      note_nxt_s = live_note_s;
      oct_nxt_s  = bus.octave;
    end else if (state_r != PLAY) begin
      note_nxt_s = 3'd0;
      oct_nxt_s  = 3'd0;
    end else if (load_s) begin
      note_nxt_s = rd_data_r[2:0];
      oct_nxt_s  = rd_data_r[5:3];
    end else begin
      note_nxt_s = note_out_r;
      oct_nxt_s  = octave_out_r;
    end

    // Read-ahead address: the entry the next playback tick will output.
    pf_addr_s = rd_done_nxt_s ? IDX_ZERO_C : rd_idx_nxt_s;
  end

  // Mode state, indices, edge detectors and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= REC_IDLE;
      count_r       <= ZERO_C;
      full_r        <= 1'b0;
      rd_idx_r      <= IDX_ZERO_C;
      rd_done_r     <= 1'b0;
      note_out_r    <= 3'd0;
      octave_out_r  <= 3'd0;
      pb_mode_r     <= 1'b0;
      toggle_prev_r <= 1'b0;
      toggle_rise_r <= 1'b0;
      clear_prev_r  <= 1'b0;
      clear_rise_r  <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      count_r       <= count_nxt_s;
      full_r        <= full_nxt_s;
      rd_idx_r      <= rd_idx_nxt_s;
      rd_done_r     <= rd_done_nxt_s;
      note_out_r    <= note_nxt_s;
      octave_out_r  <= oct_nxt_s;
      pb_mode_r     <= (state_nxt_s == PLAY);
      toggle_prev_r <= bus.toggle_pb;
      toggle_rise_r <= bus.toggle_pb & ~toggle_prev_r;
      clear_prev_r  <= bus.clear;
      clear_rise_r  <= bus.clear & ~clear_prev_r;
    end
  end

  // Note buffer storage and read-ahead register (contents are never reset).
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_s) begin
      mem_r[count_r[ADDR_W-1:0]] <= wr_data_s;
    end
    rd_data_r <= mem_r[pf_addr_s];
  end

  assign bus.note_out   = note_out_r;
  assign bus.octave_out = octave_out_r;
  assign bus.pb_mode    = pb_mode_r;
  assign bus.full       = full_r;
  assign bus.count      = count_r;

endmodule

// File: tb/tb_piano_sequencer.sv
// tb_piano_sequencer
//   Directed stimulus with hand-computed expectations. Each stimulus step
//   pushes the expected outputs for the cycle it produces into a queue; a
//   monitor on the falling clock edge pops and compares them.
module tb_piano_sequencer;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  localparam logic [6:0] SW_NONE = 7'b0000000;
  localparam logic [6:0] SW_C    = 7'b0000001;
  localparam logic [6:0] SW_D    = 7'b0000010;
  localparam logic [6:0] SW_E    = 7'b0000100;
  localparam logic [6:0] SW_G    = 7'b0010000;
  localparam logic [6:0] SW_CG   = 7'b0010001;
  localparam logic [6:0] SW_A    = 7'b0100000;
  localparam logic [6:0] SW_B    = 7'b1000000;

  typedef struct {
    int          cyc;
    string       nm;
    logic [2:0]  note;
    logic [2:0]  oct;
    logic        pb;
    logic        fl;
    logic [8:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic drain_timeout = 1'b0;
  logic drain_reported = 1'b0;

  piano_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  piano_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
      cur = exp_q.pop_front();
      n_cmp = n_cmp + 1;
      if (bus.note_out !== cur.note || bus.octave_out !== cur.oct ||
          bus.pb_mode !== cur.pb || bus.full !== cur.fl || bus.count !== cur.cnt) begin
        n_bad = n_bad + 1;
        $display("FAIL %s cyc=%0d: got note=%0d oct=%0d pb=%0b full=%0b count=%0d, want note=%0d oct=%0d pb=%0b full=%0b count=%0d",
                 cur.nm, cyc_cnt, bus.note_out, bus.octave_out, bus.pb_mode, bus.full, bus.count,
                 cur.note, cur.oct, cur.pb, cur.fl, cur.cnt);
      end
    end
    if (drain_timeout && !drain_reported) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      drain_reported = 1'b1;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
  end

  task automatic step(input logic t, input logic [6:0] sw, input logic [2:0] oc,
                      input logic tg, input logic cl);
    bus.tick          = t;
    bus.note_switches = sw;
    bus.octave        = oc;
    bus.toggle_pb     = tg;
    bus.clear         = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [2:0] n, input logic [2:0] o,
                            input logic pb, input logic fl, input logic [8:0] cnt);
    exp_t e;
    e.cyc  = cyc_cnt;
    e.nm   = nm;
    e.note = n;
    e.oct  = o;
    e.pb   = pb;
    e.fl   = fl;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [2:0] play_note [5];
    int guard;
    play_note[0] = 3'd1; play_note[1] = 3'd3; play_note[2] = 3'd0;
    play_note[3] = 3'd5; play_note[4] = 3'd1;

    rst_n             = 1'b0;
    bus.tick          = 1'b0;
    bus.note_switches = SW_NONE;
    bus.octave        = 3'd0;
    bus.toggle_pb     = 1'b0;
    bus.clear         = 1'b0;

    // Reset with random inputs.
    for (int i = 0; i < 2; i++) begin
      step(1'($urandom), 7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      expect_out("reset", 3'd0, 3'd0, 1'b0, 1'b0, 9'd0);
    end
    rst_n = 1'b1;
    step(1'b0, SW_NONE, 3'd0, 1'b0, 1'b0);
    expect_out("post_reset", 3'd0, 3'd0, 1'b0, 1'b0, 9'd0);

    // Live passthrough and arming: rests do not start a recording.
    step(1'b0, SW_NONE, 3'd4, 1'b0, 1'b0);
    expect_out("live", 3'd0, 3'd4, 1'b0, 1'b0, 9'd0);
    step(1'b1, SW_NONE, 3'd4, 1'b0, 1'b0);
    expect_out("arm_rest0", 3'd0, 3'd4, 1'b0, 1'b0, 9'd0);
    step(1'b1, SW_NONE, 3'd4, 1'b0, 1'b0);
    expect_out("arm_rest1", 3'd0, 3'd4, 1'b0, 1'b0, 9'd0);

    // Record C, E, rest, G at octave 4.
    step(1'b1, SW_C, 3'd4, 1'b0, 1'b0);
    expect_out("rec_c", 3'd1, 3'd4, 1'b0, 1'b0, 9'd1);
    step(1'b1, SW_E, 3'd4, 1'b0, 1'b0);
    expect_out("rec_e", 3'd3, 3'd4, 1'b0, 1'b0, 9'd2);
    step(1'b1, SW_NONE, 3'd4, 1'b0, 1'b0);
    expect_out("rec_rest", 3'd0, 3'd4, 1'b0, 1'b0, 9'd3);
    step(1'b1, SW_G, 3'd4, 1'b0, 1'b0);
    expect_out("rec_g", 3'd5, 3'd4, 1'b0, 1'b0, 9'd4);

    // Toggle: detected next cycle, PLAY visible the cycle after with 0/0.
    step(1'b0, SW_NONE, 3'd4, 1'b1, 1'b0);
    expect_out("tgl_detect", 3'd0, 3'd4, 1'b0, 1'b0, 9'd4);
    step(1'b0, SW_NONE, 3'd4, 1'b0, 1'b0);
    expect_out("play_entry", 3'd0, 3'd0, 1'b1, 1'b0, 9'd4);
    step(1'b0, SW_NONE, 3'd4, 1'b0, 1'b0);
    expect_out("play_hold", 3'd0, 3'd0, 1'b1, 1'b0, 9'd4);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, SW_NONE, 3'd4, 1'b0, 1'b0);
      expect_out("play4", play_note[i], 3'd4, 1'b1, 1'b0, 9'd4);
    end
`ifdef PIANO_SEQ_LOOP_EN
    step(1'b1, SW_D, 3'd4, 1'b0, 1'b0);
    expect_out("play_wrap", 3'd1, 3'd4, 1'b1, 1'b0, 9'd4);
    step(1'b0, SW_D, 3'd4, 1'b1, 1'b0);
    expect_out("loop_abort_det", 3'd1, 3'd4, 1'b1, 1'b0, 9'd4);
    step(1'b0, SW_D, 3'd4, 1'b0, 1'b0);
    expect_out("loop_abort", 3'd2, 3'd4, 1'b0, 1'b0, 9'd4);
`else
    step(1'b1, SW_D, 3'd4, 1'b0, 1'b0);
    expect_out("play_end", 3'd2, 3'd4, 1'b0, 1'b0, 9'd4);
`endif

    // Append C+G (priority encode stores C) after playback.
    step(1'b1, SW_CG, 3'd4, 1'b0, 1'b0);
    expect_out("append_cg", 3'd1, 3'd4, 1'b0, 1'b0, 9'd5);

    // Play three entries, then toggle rise together with a tick.
    step(1'b0, SW_NONE, 3'd4, 1'b1, 1'b0);
    expect_out("tgl2_detect", 3'd0, 3'd4, 1'b0, 1'b0, 9'd5);
    step(1'b0, SW_NONE, 3'd4, 1'b0, 1'b0);
    expect_out("play2_entry", 3'd0, 3'd0, 1'b1, 1'b0, 9'd5);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, SW_NONE, 3'd4, 1'b0, 1'b0);
      expect_out("play3", play_note[i], 3'd4, 1'b1, 1'b0, 9'd5);
    end
    step(1'b0, SW_NONE, 3'd4, 1'b1, 1'b0);
    expect_out("abort_detect", 3'd0, 3'd4, 1'b1, 1'b0, 9'd5);
    step(1'b1, SW_B, 3'd2, 1'b0, 1'b0);
    expect_out("abort_tick", 3'd7, 3'd2, 1'b0, 1'b0, 9'd5);
    step(1'b0, SW_B, 3'd2, 1'b0, 1'b0);
    expect_out("abort_live", 3'd7, 3'd2, 1'b0, 1'b0, 9'd5);

    // Replay all five to confirm the appended entry is C.
    step(1'b0, SW_NONE, 3'd4, 1'b1, 1'b0);
    expect_out("tgl3_detect", 3'd0, 3'd4, 1'b0, 1'b0, 9'd5);
    step(1'b0, SW_NONE, 3'd4, 1'b0, 1'b0);
    expect_out("play3_entry", 3'd0, 3'd0, 1'b1, 1'b0, 9'd5);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, SW_NONE, 3'd4, 1'b0, 1'b0);
      expect_out("play5", play_note[i], 3'd4, 1'b1, 1'b0, 9'd5);
    end
    step(1'b0, SW_NONE, 3'd4, 1'b1, 1'b0);
    expect_out("stop_detect", 3'd1, 3'd4, 1'b1, 1'b0, 9'd5);
    step(1'b0, SW_NONE, 3'd4, 1'b0, 1'b0);
    expect_out("stop", 3'd0, 3'd4, 1'b0, 1'b0, 9'd5);

    // Clear and toggle rising together during REC: clear wins.
    step(1'b1, SW_A, 3'd4, 1'b0, 1'b0);
    expect_out("rec_a", 3'd6, 3'd4, 1'b0, 1'b0, 9'd6);
    step(1'b0, SW_NONE, 3'd4, 1'b1, 1'b1);
    expect_out("clr_detect", 3'd0, 3'd4, 1'b0, 1'b0, 9'd6);
    step(1'b0, SW_NONE, 3'd4, 1'b0, 1'b0);
    expect_out("clr", 3'd0, 3'd4, 1'b0, 1'b0, 9'd0);

    // Toggle with an empty buffer is ignored.
    step(1'b0, SW_NONE, 3'd4, 1'b1, 1'b0);
    expect_out("empty_tgl_det", 3'd0, 3'd4, 1'b0, 1'b0, 9'd0);
    step(1'b0, SW_NONE, 3'd4, 1'b0, 1'b0);
    expect_out("empty_tgl", 3'd0, 3'd4, 1'b0, 1'b0, 9'd0);
    step(1'b1, SW_NONE, 3'd4, 1'b0, 1'b0);
    expect_out("empty_rest", 3'd0, 3'd4, 1'b0, 1'b0, 9'd0);

    // Fill the buffer with D, then try to write E past full.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, SW_D, 3'd3, 1'b0, 1'b0);
      expect_out("fill", 3'd2, 3'd3, 1'b0, (i == DEPTH), 9'(i));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, SW_E, 3'd3, 1'b0, 1'b0);
      expect_out("over_full", 3'd3, 3'd3, 1'b0, 1'b1, 9'd256);
    end

    // Replay the full buffer.
    step(1'b0, SW_NONE, 3'd3, 1'b1, 1'b0);
    expect_out("full_tgl_det", 3'd0, 3'd3, 1'b0, 1'b1, 9'd256);
    step(1'b0, SW_NONE, 3'd3, 1'b0, 1'b0);
    expect_out("full_play_entry", 3'd0, 3'd0, 1'b1, 1'b1, 9'd256);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, SW_NONE, 3'd3, 1'b0, 1'b0);
      expect_out("full_play", 3'd2, 3'd3, 1'b1, 1'b1, 9'd256);
    end
`ifdef PIANO_SEQ_LOOP_EN
    step(1'b1, SW_NONE, 3'd3, 1'b0, 1'b0);
    expect_out("full_wrap", 3'd2, 3'd3, 1'b1, 1'b1, 9'd256);
    step(1'b0, SW_NONE, 3'd3, 1'b1, 1'b0);
    expect_out("full_abort_det", 3'd2, 3'd3, 1'b1, 1'b1, 9'd256);
    step(1'b0, SW_NONE, 3'd3, 1'b0, 1'b0);
    expect_out("full_abort", 3'd0, 3'd3, 1'b0, 1'b1, 9'd256);
`else
    step(1'b1, SW_NONE, 3'd3, 1'b0, 1'b0);
    expect_out("full_play_end", 3'd0, 3'd3, 1'b0, 1'b1, 9'd256);
`endif

    // Reset asserted mid-operation.
    rst_n = 1'b0;
    step(1'b1, SW_D, 3'd3, 1'b0, 1'b0);
    expect_out("mid_reset", 3'd0, 3'd0, 1'b0, 1'b0, 9'd0);
    rst_n = 1'b1;
    step(1'b0, SW_NONE, 3'd3, 1'b0, 1'b0);
    expect_out("after_reset", 3'd0, 3'd3, 1'b0, 1'b0, 9'd0);

    // Let the monitor drain the queue, bounded.
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard = guard + 1;
    end
    if (exp_q.size() > 0) begin
      drain_timeout = 1'b1;
    end
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
